// File: rtl/rf_pkg.sv
// Shared types and defaults for the architectural register file.
package rf_pkg;

    localparam int RF_DATA_WIDTH = 16;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_ZERO_IDX   = 0;

    typedef enum logic {
        RF_CLEAR,
        RF_RUN
    } rf_state_t;

endpackage

// File: rtl/register_file_if.sv
// Write-back write port, decode read ports and front-end stall.
interface register_file_if
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
);

    logic [ADDR_WIDTH-1:0] WRITE_INDEX_RF;
    logic [DATA_WIDTH-1:0] WRITE_DATA_RF;
    logic                  WRITE_EN_RF;
    logic [ADDR_WIDTH-1:0] READ_INDEX_A;
    logic [ADDR_WIDTH-1:0] READ_INDEX_B;
    logic [DATA_WIDTH-1:0] READ_DATA_A;
    logic [DATA_WIDTH-1:0] READ_DATA_B;
    logic                  BUSY_RF;

    modport master (
        output WRITE_INDEX_RF, WRITE_DATA_RF, WRITE_EN_RF,
        output READ_INDEX_A, READ_INDEX_B,
        input  READ_DATA_A, READ_DATA_B, BUSY_RF
    );

    modport slave (
        input  WRITE_INDEX_RF, WRITE_DATA_RF, WRITE_EN_RF,
        input  READ_INDEX_A, READ_INDEX_B,
        output READ_DATA_A, READ_DATA_B, BUSY_RF
    );

endinterface

// File: rtl/rf_clear_seq.sv
// Post-reset clear sequencer: zeroes one entry per cycle, then enters RUN.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  busy,
    output logic                  clear_we,
    output logic [ADDR_WIDTH-1:0] clear_idx
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

    rf_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RF_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == RF_CLEAR) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LAST_IDX) begin
                state_d = RF_RUN;
            end
        end
    end

    // No clearing write on a reset edge; storage itself is never reset.
    assign busy      = (state_q == RF_CLEAR);
    assign clear_we  = busy && rst_n;
    assign clear_idx = ptr_q;

endmodule

// File: rtl/register_file.sv
// Two-read one-write register file with R0 hardwired to zero and write bypass.
module register_file
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_REGS   = 32,
    parameter bit BYPASS_EN  = 1'b1
) (
    input logic            clk,
    input logic            rst_n,
    register_file_if.slave bus
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(RF_ZERO_IDX);

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

    logic                  busy;
    logic                  clear_we;
    logic [ADDR_WIDTH-1:0] clear_idx;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  byp_en;

    rf_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_clear_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .busy      (busy),
        .clear_we  (clear_we),
        .clear_idx (clear_idx)
    );

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = bus.WRITE_INDEX_RF;
        wr_data = bus.WRITE_DATA_RF;
        if (clear_we) begin
            wr_en   = 1'b1;
            wr_idx  = clear_idx;
            wr_data = '0;
        end else if (!busy && rst_n && bus.WRITE_EN_RF
                     && bus.WRITE_INDEX_RF != ZERO_IDX) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign byp_en = BYPASS_EN && bus.WRITE_EN_RF;

    function automatic logic [DATA_WIDTH-1:0] rd_mux(
        input logic [ADDR_WIDTH-1:0] idx,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  clr,
        input logic                  byp,
        input logic [ADDR_WIDTH-1:0] w_idx,
        input logic [DATA_WIDTH-1:0] w_data
    );
        logic [DATA_WIDTH-1:0] r;
        r = stored;
        if (byp && w_idx == idx) r = w_data;
        if (clr || idx == ZERO_IDX) r = '0;
        return r;
    endfunction

    assign bus.READ_DATA_A = rd_mux(bus.READ_INDEX_A,
                                    mem_q[bus.READ_INDEX_A], busy, byp_en,
                                    bus.WRITE_INDEX_RF, bus.WRITE_DATA_RF);
    assign bus.READ_DATA_B = rd_mux(bus.READ_INDEX_B,
                                    mem_q[bus.READ_INDEX_B], busy, byp_en,
                                    bus.WRITE_INDEX_RF, bus.WRITE_DATA_RF);
    assign bus.BUSY_RF     = busy;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench: bypass and non-bypass instances driven in lockstep.
module tb_register_file;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;

    register_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) bus0 ();
    register_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) bus1 ();

    register_file #(.BYPASS_EN(1'b1)) u_byp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    register_file #(.BYPASS_EN(1'b0)) u_nobyp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    typedef struct {
        int          cyc;
        int          dut;
        logic [15:0] a;
        logic [15:0] b;
        logic        busy;
        string       name;
    } exp_t;

    exp_t q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation stamped for the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t        e;
            logic [15:0] aa, bb;
            logic        bs;
            e = q.pop_front();
            total++;
            aa = (e.dut == 0) ? bus0.READ_DATA_A : bus1.READ_DATA_A;
            bb = (e.dut == 0) ? bus0.READ_DATA_B : bus1.READ_DATA_B;
            bs = (e.dut == 0) ? bus0.BUSY_RF : bus1.BUSY_RF;
            if (e.cyc != cyc) begin
                bad++;
                $display("FAIL %s dut%0d: stale expectation cyc %0d now %0d",
                         e.name, e.dut, e.cyc, cyc);
            end else if (aa !== e.a || bb !== e.b || bs !== e.busy) begin
                bad++;
                $display("FAIL %s dut%0d cyc%0d: got a=%h b=%h busy=%b want a=%h b=%h busy=%b",
                         e.name, e.dut, cyc, aa, bb, bs, e.a, e.b, e.busy);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wi,
                         input logic [15:0] wd, input logic [4:0] ra,
                         input logic [4:0] rb);
        bus0.WRITE_EN_RF    = we;
        bus0.WRITE_INDEX_RF = wi;
        bus0.WRITE_DATA_RF  = wd;
        bus0.READ_INDEX_A   = ra;
        bus0.READ_INDEX_B   = rb;
        bus1.WRITE_EN_RF    = we;
        bus1.WRITE_INDEX_RF = wi;
        bus1.WRITE_DATA_RF  = wd;
        bus1.READ_INDEX_A   = ra;
        bus1.READ_INDEX_B   = rb;
    endtask

    task automatic expect2(input string nm, input logic [15:0] a0,
                           input logic [15:0] b0, input logic [15:0] a1,
                           input logic [15:0] b1, input logic bsy);
        q.push_back('{cyc: cyc, dut: 0, a: a0, b: b0, busy: bsy, name: nm});
        q.push_back('{cyc: cyc, dut: 1, a: a1, b: b1, busy: bsy, name: nm});
    endtask

    task automatic expect_same(input string nm, input logic [15:0] a,
                               input logic [15:0] b, input logic bsy);
        expect2(nm, a, b, a, b, bsy);
    endtask

    // Expects exactly 32 busy cycles starting now, then busy low.
    task automatic clear_window(input string nm, input int write_at);
        for (int i = 0; i < 32; i++) begin
            if (i == write_at) drive(1'b1, 5'd3, 16'hFFFF, 5'd3, 5'd3);
            else               drive(1'b0, 5'd0, 16'h0000, 5'd3, 5'd31);
            expect_same(nm, 16'h0, 16'h0, 1'b1);
            step();
        end
        drive(1'b0, 5'd0, 16'h0000, 5'd3, 5'd31);
        expect_same({nm, "_done"}, 16'h0, 16'h0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 16'h0, 5'd0, 5'd0);

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) begin
            step();
            expect_same("reset", 16'h0, 16'h0, 1'b1);
        end
        rst_n = 1'b1;
        clear_window("clear1", 1);
        step();

        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 16'h0, 5'(i), 5'(31 - i));
            expect_same("idle_zero", 16'h0, 16'h0, 1'b0);
            step();
        end

        // Bypass versus registered visibility.
        drive(1'b1, 5'd5, 16'hBEEF, 5'd5, 5'd0);
        expect2("wr_r5_same", 16'hBEEF, 16'h0, 16'h0, 16'h0, 1'b0);
        step();
        drive(1'b0, 5'd0, 16'h0, 5'd5, 5'd5);
        expect_same("wr_r5_next", 16'hBEEF, 16'hBEEF, 1'b0);
        step();

        drive(1'b1, 5'd7, 16'h7777, 5'd5, 5'd7);
        expect2("wr_r7", 16'hBEEF, 16'h7777, 16'hBEEF, 16'h0, 1'b0);
        step();

        drive(1'b1, 5'd0, 16'h1234, 5'd0, 5'd0);
        expect_same("r0_write", 16'h0, 16'h0, 1'b0);
        step();
        drive(1'b0, 5'd0, 16'h1234, 5'd0, 5'd0);
        expect_same("r0_after", 16'h0, 16'h0, 1'b0);
        step();

        drive(1'b1, 5'd31, 16'h00A5, 5'd31, 5'd31);
        expect2("dual_same", 16'h00A5, 16'h00A5, 16'h0, 16'h0, 1'b0);
        step();
        drive(1'b0, 5'd0, 16'h0, 5'd31, 5'd7);
        expect_same("dual_split", 16'h00A5, 16'h7777, 1'b0);
        step();

        drive(1'b1, 5'd3, 16'hAAAA, 5'd3, 5'd0);
        expect2("wen_gate_pre", 16'hAAAA, 16'h0, 16'h0, 16'h0, 1'b0);
        step();
        drive(1'b0, 5'd3, 16'h5555, 5'd3, 5'd3);
        expect_same("wen_gate", 16'hAAAA, 16'hAAAA, 1'b0);
        step();

        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 5'(i), 16'(i * 16'h1111), 5'd0, 5'd0);
            step();
        end
        drive(1'b0, 5'd0, 16'h0, 5'd1, 5'd4);
        expect_same("fill", 16'h1111, 16'h4444, 1'b0);
        step();

        rst_n = 1'b0;
        drive(1'b0, 5'd0, 16'h0, 5'd1, 5'd2);
        step();
        rst_n = 1'b1;
        clear_window("clear2", -1);
        step();
        drive(1'b0, 5'd0, 16'h0, 5'd1, 5'd2);
        expect_same("rezero12", 16'h0, 16'h0, 1'b0);
        step();
        drive(1'b0, 5'd0, 16'h0, 5'd3, 5'd4);
        expect_same("rezero34", 16'h0, 16'h0, 1'b0);
        step();

        // Reset pulse in the middle of a clear restarts the full window.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            expect_same("clear3_pre", 16'h0, 16'h0, 1'b1);
            step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        clear_window("clear3", -1);
        step();
        drive(1'b0, 5'd0, 16'h0, 5'd5, 5'd7);
        expect_same("rezero57", 16'h0, 16'h0, 1'b0);
        step();

        step();
        step();
        if (q.size() != 0) begin
            bad += q.size();
            $display("FAIL drain: %0d expectations unchecked, want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
